act6_full_subtractor: RTL and testbench

//   Registered ripple-borrow subtractor computing {B,D} = X - Y - Z.

---
 rtl/act6_full_subtractor_if.sv | 23 ++
 rtl/act6_full_subtractor.sv | 47 ++++
 tb/tb_act6_full_subtractor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/act6_full_subtractor_if.sv
// Operand/result bundle for the ACT6 registered full subtractor.
// The master drives operands and valid; the slave (the subtractor) returns the registered result.
interface act6_full_subtractor_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             Z;
    logic [WIDTH-1:0] D;
    logic             B;
    logic             out_valid;

    modport master (
        output in_valid, X, Y, Z,
        input  D, B, out_valid
    );

    modport slave (
        input  in_valid, X, Y, Z,
        output D, B, out_valid
    );
endinterface

// File: rtl/act6_full_subtractor.sv
// Registered ripple-borrow subtractor: {B,D} = X - Y - Z, one gate-level cell per bit,
// with a single output register stage (latency 1, full throughput).
module act6_full_subtractor #(
    parameter int WIDTH = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    act6_full_subtractor_if.slave    bus
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;

    assign borrow[0] = bus.Z;

    // Stage p0: combinational borrow chain, LSB to MSB
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic x_n;
        assign x_n           = ~bus.X[i];
        assign diff[i]       = bus.X[i] ^ bus.Y[i] ^ borrow[i];
        assign borrow[i + 1] = (x_n & bus.Y[i]) | (x_n & borrow[i]) | (bus.Y[i] & borrow[i]);
    end

    logic [WIDTH-1:0] d_p1;
    logic             b_p1;
    logic             vld_p1;

    // Stage p1: output register; results hold when no valid operand arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_p1   <= '0;
            b_p1   <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                d_p1 <= diff;
                b_p1 <= borrow[WIDTH];
            end
        end
    end

    assign bus.D         = d_p1;
    assign bus.B         = b_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_act6_full_subtractor.sv
// Directed bench for act6_full_subtractor: a 1-bit and an 8-bit instance driven side by side
// with hand-computed expected results checked one clock after each operand.
module tb_act6_full_subtractor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    act6_full_subtractor_if #(.WIDTH(1)) bus1 ();
    act6_full_subtractor_if #(.WIDTH(8)) bus8 ();

    act6_full_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    act6_full_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic x, input logic y, input logic z);
        bus1.in_valid = v;
        bus1.X        = x;
        bus1.Y        = y;
        bus1.Z        = z;
    endtask

    task automatic drv8(input logic v, input logic [7:0] x, input logic [7:0] y, input logic z);
        bus8.in_valid = v;
        bus8.X        = x;
        bus8.Y        = y;
        bus8.Z        = z;
    endtask

    logic [7:0] d_tab;
    logic [7:0] b_tab;
    logic [2:0] xyz;

    initial begin
        checks = 0;
        errors = 0;
        // Truth table indexed by {X,Y,Z}
        d_tab = 8'b1001_0110;
        b_tab = 8'b1000_1110;

        // Reset held for two edges while a valid operand is presented
        rst_n = 1'b0;
        drv1(1'b1, 1'b1, 1'b0, 1'b0);
        drv8(1'b1, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_d1",   32'(bus1.D), 32'h0);
            chk("rst_b1",   32'(bus1.B), 32'h0);
            chk("rst_v1",   32'(bus1.out_valid), 32'h0);
            chk("rst_d8",   32'(bus8.D), 32'h0);
            chk("rst_b8",   32'(bus8.B), 32'h0);
            chk("rst_v8",   32'(bus8.out_valid), 32'h0);
        end
        rst_n = 1'b1;

        // Exhaustive 1-bit sweep
        for (int i = 0; i < 8; i++) begin
            xyz = 3'(i);
            drv1(1'b1, xyz[2], xyz[1], xyz[0]);
            step();
            chk($sformatf("tt_d_%0d", i), 32'(bus1.D), 32'(d_tab[i]));
            chk($sformatf("tt_b_%0d", i), 32'(bus1.B), 32'(b_tab[i]));
            chk($sformatf("tt_v_%0d", i), 32'(bus1.out_valid), 32'h1);
        end

        // 1-bit spot checks alongside 8-bit wrap-around and plain subtraction
        drv1(1'b1, 1'b0, 1'b1, 1'b1);
        drv8(1'b1, 8'h00, 8'hFF, 1'b1);
        step();
        chk("spot1_d", 32'(bus1.D), 32'h0);
        chk("spot1_b", 32'(bus1.B), 32'h1);
        chk("wrap_d8", 32'(bus8.D), 32'h00);
        chk("wrap_b8", 32'(bus8.B), 32'h1);
        chk("wrap_v8", 32'(bus8.out_valid), 32'h1);

        drv1(1'b1, 1'b1, 1'b0, 1'b0);
        drv8(1'b1, 8'h50, 8'h20, 1'b0);
        step();
        chk("spot2_d", 32'(bus1.D), 32'h1);
        chk("spot2_b", 32'(bus1.B), 32'h0);
        chk("sub_d8",  32'(bus8.D), 32'h30);
        chk("sub_b8",  32'(bus8.B), 32'h0);

        // Borrow rippling through several bits: 0x10 - 0x01 - 1 = 0x0E
        drv8(1'b1, 8'h10, 8'h01, 1'b1);
        step();
        chk("rip_d8", 32'(bus8.D), 32'h0E);
        chk("rip_b8", 32'(bus8.B), 32'h0);

        // Hold: valid op then idle cycle with different inputs
        drv1(1'b1, 1'b1, 1'b0, 1'b0);
        drv8(1'b1, 8'h05, 8'h07, 1'b0);
        step();
        chk("hold_v1a", 32'(bus1.out_valid), 32'h1);
        chk("hold_d8a", 32'(bus8.D), 32'hFE);
        chk("hold_b8a", 32'(bus8.B), 32'h1);
        drv1(1'b0, 1'b0, 1'b1, 1'b1);
        drv8(1'b0, 8'hAA, 8'h11, 1'b0);
        step();
        chk("hold_d1", 32'(bus1.D), 32'h1);
        chk("hold_b1", 32'(bus1.B), 32'h0);
        chk("hold_v1b", 32'(bus1.out_valid), 32'h0);
        chk("hold_d8b", 32'(bus8.D), 32'hFE);
        chk("hold_b8b", 32'(bus8.B), 32'h1);
        chk("hold_v8b", 32'(bus8.out_valid), 32'h0);

        // Mid-stream reset between back-to-back valid operands
        drv1(1'b1, 1'b0, 1'b0, 1'b1);
        drv8(1'b1, 8'h03, 8'h09, 1'b0);
        step();
        chk("ms_d1a", 32'(bus1.D), 32'h1);
        chk("ms_b1a", 32'(bus1.B), 32'h1);
        chk("ms_d8a", 32'(bus8.D), 32'hFA);
        drv1(1'b1, 1'b1, 1'b1, 1'b1);
        drv8(1'b1, 8'hFF, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        chk("ms_rst_d1", 32'(bus1.D), 32'h0);
        chk("ms_rst_b1", 32'(bus1.B), 32'h0);
        chk("ms_rst_v1", 32'(bus1.out_valid), 32'h0);
        chk("ms_rst_d8", 32'(bus8.D), 32'h0);
        chk("ms_rst_v8", 32'(bus8.out_valid), 32'h0);
        rst_n = 1'b1;
        drv1(1'b1, 1'b1, 1'b1, 1'b1);
        drv8(1'b1, 8'hC8, 8'h64, 1'b1);
        step();
        chk("ms_res_d1", 32'(bus1.D), 32'h1);
        chk("ms_res_b1", 32'(bus1.B), 32'h1);
        chk("ms_res_v1", 32'(bus1.out_valid), 32'h1);
        chk("ms_res_d8", 32'(bus8.D), 32'h63);
        chk("ms_res_b8", 32'(bus8.B), 32'h0);
        chk("ms_res_v8", 32'(bus8.out_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
